// File: rtl/dcache_tag_pkg.sv
// Shared constants and types for the dcache tag controller.
package dcache_tag_pkg;

  localparam int unsigned INDEX_WIDTH = 4;
  localparam int unsigned TAG_WIDTH   = 22;
  localparam int unsigned ENTRY_WIDTH = TAG_WIDTH + 2;
  localparam int unsigned NUM_SETS    = 1 << INDEX_WIDTH;

  // Stored tag word: bit 23 valid, bit 22 dirty, bits 21:0 tag.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } tag_entry_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// Pipeline-side lookup / response / update bundle for the tag controller.
interface dcache_tag_ctrl_if;
  import dcache_tag_pkg::*;

  logic                   lkp_valid;
  logic                   lkp_ready;
  logic [INDEX_WIDTH-1:0] lkp_index;
  logic [TAG_WIDTH-1:0]   lkp_tag;

  logic                   resp_valid;
  logic                   resp_hit;
  logic                   resp_valid_bit;
  logic                   resp_dirty;
  logic [TAG_WIDTH-1:0]   resp_tag;

  logic                   upd_valid;
  logic                   upd_ready;
  logic [INDEX_WIDTH-1:0] upd_index;
  tag_entry_t             upd_entry;

  modport master (
    output lkp_valid, lkp_index, lkp_tag, upd_valid, upd_index, upd_entry,
    input  lkp_ready, upd_ready,
    input  resp_valid, resp_hit, resp_valid_bit, resp_dirty, resp_tag
  );

  modport slave (
    input  lkp_valid, lkp_index, lkp_tag, upd_valid, upd_index, upd_entry,
    output lkp_ready, upd_ready,
    output resp_valid, resp_hit, resp_valid_bit, resp_dirty, resp_tag
  );

endinterface

// File: rtl/dcache_tag_ctrl.sv
// Tag SRAM sequencer: clear sweep, one lookup and one update per cycle,
// same-cycle update-to-lookup forwarding.
module dcache_tag_ctrl
  import dcache_tag_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inv_all,
  output logic                   init_done,
  dcache_tag_ctrl_if.slave       bus,
  output logic                   sram_csb0,
  output logic                   sram_web0,
  output logic [INDEX_WIDTH-1:0] sram_addr0,
  output logic [ENTRY_WIDTH-1:0] sram_din0,
  input  logic [ENTRY_WIDTH-1:0] sram_dout0,
  output logic                   sram_csb1,
  output logic [INDEX_WIDTH-1:0] sram_addr1,
  input  logic [ENTRY_WIDTH-1:0] sram_dout1
);

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   wr_q;
  logic                   resp_valid_q;
  logic                   fwd_q;
  tag_entry_t             fwd_entry_q;
  logic [TAG_WIDTH-1:0]   tag_q;

  logic                   ready_c;
  logic                   lkp_fire_c;
  logic                   upd_fire_c;
  tag_entry_t             resp_entry_c;
  logic                   unused_dout0;

  // Port 0 read data has no consumer.
  assign unused_dout0 = ^sram_dout0;

  // State and sweep-index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: sweep all sets, then serve until invalidate-all.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + INDEX_WIDTH'(1);
        if (idx_q == INDEX_WIDTH'(NUM_SETS - 1)) begin
          state_d = READY;
          idx_d   = '0;
        end
      end
      READY: begin
        if (inv_all) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // SRAM pin sequencing and handshake; everything idles while rst is high.
  always_comb begin
    init_done  = 1'b0;
    ready_c    = 1'b0;
    lkp_fire_c = 1'b0;
    upd_fire_c = 1'b0;
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    sram_csb1  = 1'b1;
    sram_addr1 = '0;
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          sram_csb0  = 1'b0;
          sram_web0  = 1'b0;
          sram_addr0 = idx_q;
        end
        READY: begin
          init_done  = 1'b1;
          ready_c    = ~inv_all;
          upd_fire_c = bus.upd_valid & ready_c;
          lkp_fire_c = bus.lkp_valid & ready_c;
          if (upd_fire_c) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = bus.upd_index;
            sram_din0  = bus.upd_entry;
          end else if (wr_q) begin
            // Registered write enable is sticky: select once with web0=1.
            sram_csb0 = 1'b0;
          end
          if (lkp_fire_c) begin
            sram_csb1  = 1'b0;
            sram_addr1 = bus.lkp_index;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.lkp_ready = ready_c;
  assign bus.upd_ready = ready_c;

  // Lookup context for the response cycle, plus write-history for disarm.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      fwd_q        <= 1'b0;
      fwd_entry_q  <= '0;
      tag_q        <= '0;
      wr_q         <= 1'b0;
    end else begin
      resp_valid_q <= lkp_fire_c;
      wr_q         <= ~sram_csb0 & ~sram_web0;
      if (lkp_fire_c) begin
        tag_q       <= bus.lkp_tag;
        fwd_q       <= upd_fire_c & (bus.upd_index == bus.lkp_index);
        fwd_entry_q <= bus.upd_entry;
      end
    end
  end

  // Response: forwarded entry or SRAM read data against the registered tag.
  always_comb begin
    resp_entry_c = fwd_q ? fwd_entry_q : tag_entry_t'(sram_dout1);
  end

  assign bus.resp_valid     = resp_valid_q & ~rst;
  assign bus.resp_hit       = resp_entry_c.valid & (resp_entry_c.tag == tag_q);
  assign bus.resp_valid_bit = resp_entry_c.valid;
  assign bus.resp_dirty     = resp_entry_c.dirty;
  assign bus.resp_tag       = resp_entry_c.tag;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Randomized bench for dcache_tag_ctrl with a behavioural tag SRAM and a
// set-array reference model.
module tb_dcache_tag_ctrl;
  import dcache_tag_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic inv_all;
  logic init_done;
  logic                   sram_csb0, sram_web0, sram_csb1;
  logic [INDEX_WIDTH-1:0] sram_addr0, sram_addr1;
  logic [ENTRY_WIDTH-1:0] sram_din0, sram_dout0, sram_dout1;

  dcache_tag_ctrl_if bus ();

  dcache_tag_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .inv_all    (inv_all),
    .init_done  (init_done),
    .bus        (bus),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  always #5 clk = ~clk;

  // Tag SRAM: write at the edge, reads return pre-edge contents next cycle.
  logic [ENTRY_WIDTH-1:0] sram_mem [NUM_SETS];
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0) sram_mem[sram_addr0] <= sram_din0;
    if (!sram_csb0 && sram_web0)  sram_dout0 <= sram_mem[sram_addr0];
    if (!sram_csb1)               sram_dout1 <= sram_mem[sram_addr1];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  tag_entry_t           exp_mem [NUM_SETS];
  int                   sweep_cnt = 0;
  bit                   prev_wr   = 1'b0;
  bit                   pend_valid = 1'b0;
  tag_entry_t           pend_entry;
  logic [TAG_WIDTH-1:0] pend_tag;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    inv_all       = 1'b0;
    bus.lkp_valid = 1'b0;
    bus.lkp_index = '0;
    bus.lkp_tag   = '0;
    bus.upd_valid = 1'b0;
    bus.upd_index = '0;
    bus.upd_entry = '0;
  endtask

  // Check one cycle against the model at the falling edge, then advance.
  task automatic tick();
    bit         this_wr = 1'b0;
    bit         rdy, u, l;
    bit         nxt_valid = 1'b0;
    tag_entry_t nxt_entry = '0;
    @(negedge clk);
    if (rst) begin
      check_val("resp_valid_rst", 32'(bus.resp_valid), 32'(0));
    end else begin
      check_val("resp_valid", 32'(bus.resp_valid), 32'(pend_valid));
      if (pend_valid) begin
        check_val("resp_hit", 32'(bus.resp_hit),
                  32'(pend_entry.valid && (pend_entry.tag == pend_tag)));
        check_val("resp_valid_bit", 32'(bus.resp_valid_bit), 32'(pend_entry.valid));
        check_val("resp_dirty", 32'(bus.resp_dirty), 32'(pend_entry.dirty));
        check_val("resp_tag", 32'(bus.resp_tag), 32'(pend_entry.tag));
      end
    end
    if (rst) begin
      check_val("init_done_rst", 32'(init_done), 32'(0));
      check_val("lkp_ready_rst", 32'(bus.lkp_ready), 32'(0));
      check_val("upd_ready_rst", 32'(bus.upd_ready), 32'(0));
      check_val("csb0_rst", 32'(sram_csb0), 32'(1));
      check_val("web0_rst", 32'(sram_web0), 32'(1));
      check_val("csb1_rst", 32'(sram_csb1), 32'(1));
      check_val("addr0_rst", 32'(sram_addr0), 32'(0));
      check_val("din0_rst", 32'(sram_din0), 32'(0));
      check_val("addr1_rst", 32'(sram_addr1), 32'(0));
      sweep_cnt = 0;
    end else if (sweep_cnt < int'(NUM_SETS)) begin
      check_val("init_done_clr", 32'(init_done), 32'(0));
      check_val("lkp_ready_clr", 32'(bus.lkp_ready), 32'(0));
      check_val("upd_ready_clr", 32'(bus.upd_ready), 32'(0));
      check_val("csb0_clr", 32'(sram_csb0), 32'(0));
      check_val("web0_clr", 32'(sram_web0), 32'(0));
      check_val("addr0_clr", 32'(sram_addr0), 32'(sweep_cnt));
      check_val("din0_clr", 32'(sram_din0), 32'(0));
      check_val("csb1_clr", 32'(sram_csb1), 32'(1));
      exp_mem[INDEX_WIDTH'(sweep_cnt)] = '0;
      this_wr = 1'b1;
      sweep_cnt++;
    end else begin
      rdy = !inv_all;
      u   = bus.upd_valid && rdy;
      l   = bus.lkp_valid && rdy;
      check_val("init_done", 32'(init_done), 32'(1));
      check_val("lkp_ready", 32'(bus.lkp_ready), 32'(rdy));
      check_val("upd_ready", 32'(bus.upd_ready), 32'(rdy));
      if (u) begin
        check_val("csb0_wr", 32'(sram_csb0), 32'(0));
        check_val("web0_wr", 32'(sram_web0), 32'(0));
        check_val("addr0_wr", 32'(sram_addr0), 32'(bus.upd_index));
        check_val("din0_wr", 32'(sram_din0), 32'(bus.upd_entry));
        exp_mem[bus.upd_index] = bus.upd_entry;
        this_wr = 1'b1;
      end else if (prev_wr) begin
        check_val("csb0_disarm", 32'(sram_csb0), 32'(0));
        check_val("web0_disarm", 32'(sram_web0), 32'(1));
      end else begin
        check_val("csb0_idle", 32'(sram_csb0), 32'(1));
      end
      if (l) begin
        check_val("csb1_rd", 32'(sram_csb1), 32'(0));
        check_val("addr1_rd", 32'(sram_addr1), 32'(bus.lkp_index));
        nxt_valid = 1'b1;
        nxt_entry = exp_mem[bus.lkp_index];
        pend_tag  = bus.lkp_tag;
      end else begin
        check_val("csb1_idle", 32'(sram_csb1), 32'(1));
      end
      if (inv_all) sweep_cnt = 0;
    end
    pend_valid = nxt_valid;
    pend_entry = nxt_entry;
    prev_wr    = this_wr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [INDEX_WIDTH-1:0] idx,
                           input logic [TAG_WIDTH-1:0] tag);
    bus.lkp_valid = 1'b1;
    bus.lkp_index = idx;
    bus.lkp_tag   = tag;
  endtask

  task automatic do_update(input logic [INDEX_WIDTH-1:0] idx,
                           input tag_entry_t ent);
    bus.upd_valid = 1'b1;
    bus.upd_index = idx;
    bus.upd_entry = ent;
  endtask

  task automatic sweep_wait();
    for (int i = 0; i < int'(NUM_SETS); i++) tick();
  endtask

  task automatic random_cycle(input int inv_rate);
    set_idle();
    if ($urandom_range(0, 3) != 0)
      do_lookup(INDEX_WIDTH'($urandom_range(0, 15)), TAG_WIDTH'($urandom_range(0, 3)));
    if ($urandom_range(0, 2) != 0)
      do_update(INDEX_WIDTH'($urandom_range(0, 15)),
                '{valid: 1'($urandom_range(0, 1)), dirty: 1'($urandom_range(0, 1)),
                  tag: TAG_WIDTH'($urandom_range(0, 3))});
    if (inv_rate > 0 && $urandom_range(0, inv_rate) == 0) inv_all = 1'b1;
    tick();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Clear sweep then first lookups miss on a cleared set.
    sweep_wait();
    do_lookup(4'd5, 22'h1);
    tick();
    set_idle();

    // Update then lookup on the following cycle.
    do_update(4'd3, '{valid: 1'b1, dirty: 1'b0, tag: 22'h2A5A5});
    tick();
    set_idle();
    do_lookup(4'd3, 22'h2A5A5);
    tick();
    set_idle();
    tick();
    tick();

    // Same-cycle update and lookup on the same set (forwarded).
    do_update(4'd7, '{valid: 1'b1, dirty: 1'b1, tag: 22'h00123});
    do_lookup(4'd7, 22'h00123);
    tick();
    set_idle();
    tick();
    tick();

    // Fill each set with tag = index, then back-to-back lookups.
    for (int i = 0; i < int'(NUM_SETS); i++) begin
      set_idle();
      do_update(INDEX_WIDTH'(i), '{valid: 1'b1, dirty: 1'(i & 1), tag: TAG_WIDTH'(i)});
      tick();
    end
    for (int i = 0; i < int'(NUM_SETS); i++) begin
      set_idle();
      do_lookup(INDEX_WIDTH'(i), TAG_WIDTH'(i));
      tick();
    end
    set_idle();
    do_lookup(4'd9, 22'h3FFFFF);
    tick();
    set_idle();
    do_lookup(4'd9, 22'h200009);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) random_cycle(0);

    // Reset right after an accepted lookup.
    set_idle();
    do_lookup(4'd2, 22'h2);
    tick();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_wait();
    for (int i = 0; i < 8; i++) begin
      set_idle();
      do_lookup(INDEX_WIDTH'($urandom_range(0, 15)), TAG_WIDTH'(0));
      tick();
    end

    // Invalidate-all with requests presented in the same cycle.
    for (int i = 0; i < 40; i++) random_cycle(0);
    set_idle();
    do_update(4'd4, '{valid: 1'b1, dirty: 1'b1, tag: 22'h4});
    do_lookup(4'd4, 22'h4);
    inv_all = 1'b1;
    tick();
    for (int i = 0; i < int'(NUM_SETS); i++) begin
      set_idle();
      do_lookup(INDEX_WIDTH'(i), TAG_WIDTH'(i));
      tick();
    end
    for (int i = 0; i < int'(NUM_SETS); i++) begin
      set_idle();
      do_lookup(INDEX_WIDTH'(i), TAG_WIDTH'(0));
      tick();
    end

    // Random traffic with occasional invalidate-all.
    for (int i = 0; i < 300; i++) random_cycle(40);

    set_idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
